// File: rtl/n64_pkg.sv
// n64_pkg: shared Joybus constants, FSM states and reply-to-button mapping.
package n64_pkg;
  typedef enum logic [2:0] {IDLE, TX, RX_WAIT, RX_BIT, RX_STOP, UPDATE, ERROR} state_t;
  localparam logic [7:0] POLL_CMD = 8'h01;
  localparam int RESP_BITS = 32;
  localparam int TX_BITS = 9;
  localparam int US_SHORT = 1;
  localparam int US_SAMPLE = 2;
  localparam int US_LONG = 3;
  localparam int US_BIT = 4;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  localparam int BTN_SELECT = 5;
  localparam int BTN_A = 6;
  localparam int BTN_B = 7;
  localparam int BTN_X = 8;
  localparam int BTN_Y = 9;
  localparam int BTN_L = 10;
  localparam int BTN_R = 11;
  // lr = {L, R}, c_dl = {Cdown, Cleft}; stick beyond the threshold folds into the D-pad
  function automatic logic [11:0] map_buttons(input logic [7:0] b0, input logic [1:0] lr,
                                              input logic [1:0] c_dl, input logic [7:0] x,
                                              input logic [7:0] y, input int thresh);
    logic [11:0] m;
    m = '0;
    m[BTN_UP] = b0[3] | (int'($signed(y)) > thresh);
    m[BTN_DOWN] = b0[2] | (int'($signed(y)) < -thresh);
    m[BTN_LEFT] = b0[1] | (int'($signed(x)) < -thresh);
    m[BTN_RIGHT] = b0[0] | (int'($signed(x)) > thresh);
    m[BTN_START] = b0[4];
    m[BTN_SELECT] = b0[5];
    m[BTN_A] = b0[7];
    m[BTN_B] = b0[6];
    m[BTN_X] = c_dl[0];
    m[BTN_Y] = c_dl[1];
    m[BTN_L] = lr[1];
    m[BTN_R] = lr[0];
    return m;
  endfunction
endpackage

// File: rtl/n64_joybus_poller_line_sync.sv
// n64_line_sync: two-flop synchroniser for the Joybus pin plus falling-edge pulse.
module n64_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {r_meta, r_sync, r_prev} <= 3'b111;
    else {r_meta, r_sync, r_prev} <= {i_line, r_meta, r_sync};
  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/n64_joybus_poller.sv
// n64_joybus_poller: periodic Joybus poll (0x01) and 32-bit status deserialiser
// driving the shared 12-bit button vector and signed stick outputs.
module n64_joybus_poller
  import n64_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int POLL_PERIOD_US = 16000,
  parameter int TIMEOUT_US = 200,
  parameter int STICK_THRESH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_n64_in,
  output logic        o_n64_oe,
  output logic [11:0] o_buttons,
  output logic [7:0]  o_stick_x,
  output logic [7:0]  o_stick_y,
  output logic        o_valid,
  output logic        o_present,
  output logic        o_err
);
  localparam int US_CYC = CLK_FREQ_HZ / 1000000;
  state_t r_state;
  logic [15:0] r_pre, r_us;
  logic [8:0] r_tx_sr;
  logic [3:0] r_tx_bit;
  logic [5:0] r_rx_cnt;
  logic [31:0] r_shift;
  logic r_stop_fell;
  logic w_sync, w_fall, w_tick;
  logic [15:0] w_low_us;
  n64_line_sync u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_line (i_n64_in),
    .o_sync (w_sync),
    .o_fall (w_fall)
  );
  // prescaler restarts on every phase change so all bit timing is edge-relative
  assign w_tick = r_pre == 16'(US_CYC - 1);
  assign w_low_us = r_tx_sr[8] ? 16'(US_SHORT) : 16'(US_LONG);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pre <= '0;
      r_us <= '0;
      r_tx_sr <= '0;
      r_tx_bit <= '0;
      r_rx_cnt <= '0;
      r_shift <= '0;
      r_stop_fell <= 1'b0;
      o_n64_oe <= 1'b0;
      o_buttons <= '0;
      o_stick_x <= '0;
      o_stick_y <= '0;
      o_valid <= 1'b0;
      o_present <= 1'b0;
      o_err <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 16'd1;
      if (w_tick) r_us <= r_us + 16'd1;
      o_valid <= 1'b0;
      o_err <= 1'b0;
      o_n64_oe <= 1'b0;
      case (r_state)
        IDLE:
          if (w_tick && r_us == 16'(POLL_PERIOD_US - 1)) begin
            r_state <= TX;
            r_us <= '0;
            r_tx_sr <= {POLL_CMD, 1'b1};
            r_tx_bit <= '0;
          end
        TX: begin
          o_n64_oe <= r_us < w_low_us;
          if (w_tick && r_us == 16'(US_BIT - 1)) begin
            r_us <= '0;
            r_tx_sr <= r_tx_sr << 1;
            r_tx_bit <= r_tx_bit + 4'd1;
            if (r_tx_bit == 4'(TX_BITS - 1)) begin
              r_state <= RX_WAIT;
              r_rx_cnt <= '0;
            end
          end
        end
        RX_WAIT:
          if (w_fall) begin
            r_state <= RX_BIT;
            r_pre <= '0;
            r_us <= '0;
          end else if (w_tick && r_us == 16'(TIMEOUT_US - 1)) r_state <= ERROR;
        RX_BIT:
          if (w_tick && r_us == 16'(US_SAMPLE - 1)) begin
            r_shift <= {r_shift[30:0], w_sync};
            r_rx_cnt <= r_rx_cnt + 6'd1;
            r_us <= '0;
            r_stop_fell <= 1'b0;
            r_state <= r_rx_cnt == 6'(RESP_BITS - 1) ? RX_STOP : RX_WAIT;
          end
        RX_STOP:
          if (!r_stop_fell && w_fall) begin
            r_stop_fell <= 1'b1;
            r_pre <= '0;
            r_us <= '0;
          end else if (r_stop_fell && w_sync) r_state <= UPDATE;
          else if (w_tick && r_us == 16'(TIMEOUT_US - 1)) r_state <= ERROR;
        UPDATE: begin
          o_buttons <= map_buttons(r_shift[31:24], r_shift[21:20], r_shift[18:17],
                                   r_shift[15:8], r_shift[7:0], STICK_THRESH);
          o_stick_x <= r_shift[15:8];
          o_stick_y <= r_shift[7:0];
          o_valid <= 1'b1;
          o_present <= 1'b1;
          r_state <= IDLE;
          r_pre <= '0;
          r_us <= '0;
        end
        ERROR: begin
          o_err <= 1'b1;
          o_present <= 1'b0;
          o_buttons <= '0;
          o_stick_x <= '0;
          o_stick_y <= '0;
          r_state <= IDLE;
          r_pre <= '0;
          r_us <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n64_joybus_poller.sv
// tb_n64_joybus_poller: controller model on an open-drain line, table-driven and
// random replies checked against a byte-level mapping model.
module tb_n64_joybus_poller;
  localparam int CLK_HZ = 12000000;
  localparam int POLL_US = 100;
  localparam int TO_US = 200;
  localparam int TH = 32;
  localparam int US = CLK_HZ / 1000000;
  localparam int POLL_CYC = POLL_US * US;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctl_low = 1'b0;
  logic oe, valid, present, err;
  logic [11:0] buttons;
  logic [7:0] sx, sy;
  wire line = ~(oe | ctl_low);
  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;

  n64_joybus_poller #(
    .CLK_FREQ_HZ(CLK_HZ),
    .POLL_PERIOD_US(POLL_US),
    .TIMEOUT_US(TO_US),
    .STICK_THRESH(TH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_n64_in(line),
    .o_n64_oe(oe),
    .o_buttons(buttons),
    .o_stick_x(sx),
    .o_stick_y(sy),
    .o_valid(valid),
    .o_present(present),
    .o_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (err) n_err++;
  end

  typedef struct {
    logic [31:0] d;
    int nbits;
    logic ok;
    logic [11:0] btn;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: sign-extend the stick bytes and apply the button table directly
  function automatic logic [11:0] model(input logic [31:0] r);
    int x, y;
    logic [7:0] b0, b1;
    b0 = r[31:24];
    b1 = r[23:16];
    x = int'(r[15:8]);
    y = int'(r[7:0]);
    if (x > 127) x -= 256;
    if (y > 127) y -= 256;
    return {b1[4], b1[5], b1[2], b1[1], b0[6], b0[7], b0[5], b0[4],
            b0[0] | (x > TH), b0[1] | (x < -TH), b0[2] | (y < -TH), b0[3] | (y > TH)};
  endfunction

  task automatic wait_rise(output int t);
    t = 0;
    while (!oe && t < 3 * POLL_CYC + 3000) begin
      @(negedge clk);
      t++;
    end
    check_range("poll_start_bound", t, 0, 3 * POLL_CYC + 2999);
  endtask

  task automatic drive_bit(input logic b);
    ctl_low = 1'b1;
    repeat (b ? US : 3 * US) @(negedge clk);
    ctl_low = 1'b0;
    repeat (b ? 3 * US : US) @(negedge clk);
  endtask

  task automatic send_reply(input logic [31:0] d, input int nbits, input logic stop);
    for (int i = 0; i < nbits; i++) drive_bit(d[31-i]);
    if (stop) begin
      ctl_low = 1'b1;
      repeat (US) @(negedge clk);
      ctl_low = 1'b0;
      repeat (2 * US) @(negedge clk);
    end
  endtask

  // Called with oe just seen high: let the 36 us command finish, then answer
  task automatic reply_phase(input logic [31:0] d, input int nbits, input logic stop,
                             output int dv, output int de);
    int v0, e0, t;
    repeat (38 * US) @(negedge clk);
    v0 = n_valid;
    e0 = n_err;
    send_reply(d, nbits, stop);
    t = 0;
    while (n_valid == v0 && n_err == e0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    dv = n_valid - v0;
    de = n_err - e0;
  endtask

  task automatic check_result(input string tag, input int dv, input int de, input logic ok,
                              input logic [11:0] btn, input logic [7:0] ex, input logic [7:0] ey);
    check({tag, "_valid"}, 64'(dv), ok ? 64'd1 : 64'd0);
    check({tag, "_err"}, 64'(de), ok ? 64'd0 : 64'd1);
    check({tag, "_buttons"}, 64'(buttons), 64'(btn));
    check({tag, "_stick"}, {48'd0, sx, sy}, {48'd0, ex, ey});
    check({tag, "_present"}, 64'(present), 64'(ok));
  endtask

  initial begin
    int t, hi, lo, dv, de;
    logic seen;
    logic [31:0] d;
    vecs[0] = '{32'h9000_0000, 32, 1'b1, 12'h050};
    vecs[1] = '{32'h0000_0028, 32, 1'b1, 12'h001};
    vecs[2] = '{32'h0000_0020, 32, 1'b1, 12'h000};
    vecs[3] = '{32'h0000_8000, 32, 1'b1, 12'h004};
    vecs[4] = '{32'h2032_0000, 32, 1'b1, 12'hD20};
    vecs[5] = '{32'h0000_00DF, 32, 1'b1, 12'h002};
    vecs[6] = '{32'h0000_2100, 32, 1'b1, 12'h008};
    vecs[7] = '{32'h0F00_0081, 32, 1'b1, 12'h00F};
    vecs[8] = '{32'hFFFF_FFFF, 20, 1'b0, 12'h000};

    repeat (4) @(negedge clk);
    check("reset_outputs", 64'({oe, buttons, sx, sy, valid, present, err}), 64'd0);
    rst_n = 1'b1;
    wait_rise(t);
    check_range("first_poll", t, POLL_CYC - 5, POLL_CYC + 5);

    for (int b = 0; b < 9; b++) begin
      hi = 0;
      while (oe && hi < 100) begin
        @(negedge clk);
        hi++;
      end
      check(.name($sformatf("tx_bit%0d_low", b)), .act(64'(hi)), .exp(b < 7 ? 64'd36 : 64'd12));
      if (b < 8) begin
        lo = 0;
        while (!oe && lo < 100) begin
          @(negedge clk);
          lo++;
        end
        check(.name($sformatf("tx_bit%0d_rel", b)), .act(64'(lo)), .exp(b < 7 ? 64'd12 : 64'd36));
      end
    end

    t = 0;
    seen = 1'b0;
    while (!err && t < 4000) begin
      @(negedge clk);
      t++;
      seen |= oe;
    end
    check_range("no_reply_err_time", t, 35 + TO_US * US - 5, 35 + TO_US * US + 5);
    check("released_after_tx", 64'(seen), 64'd0);
    check("err_outputs", 64'({buttons, sx, sy, present}), 64'd0);
    @(negedge clk);
    check("err_one_cycle", 64'(err), 64'd0);

    for (int i = 0; i < 9; i++) begin
      wait_rise(t);
      if (i == 0) check_range("poll_after_err", t, POLL_CYC - 5, POLL_CYC + 5);
      reply_phase(vecs[i].d, vecs[i].nbits, vecs[i].ok, dv, de);
      check_result($sformatf("vec%0d", i), dv, de, vecs[i].ok, vecs[i].btn,
                   vecs[i].ok ? vecs[i].d[15:8] : 8'h00, vecs[i].ok ? vecs[i].d[7:0] : 8'h00);
    end

    for (int i = 0; i < 6; i++) begin
      d = $urandom();
      wait_rise(t);
      reply_phase(d, 32, 1'b1, dv, de);
      check_result($sformatf("rand%0d", i), dv, de, 1'b1, model(d), d[15:8], d[7:0]);
    end

    wait_rise(t);
    reply_phase(32'h9000_0000, 32, 1'b1, dv, de);
    check_result("pre_reset", dv, de, 1'b1, 12'h050, 8'h00, 8'h00);

    wait_rise(t);
    repeat (38 * US) @(negedge clk);
    send_reply(32'hFFFF_FFFF, 14, 1'b0);
    ctl_low = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_rx", 64'({oe, buttons, sx, sy, valid, present, err}), 64'd0);
    ctl_low = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_rise(t);
    check_range("poll_after_reset", t, POLL_CYC - 5, POLL_CYC + 5);
    reply_phase(32'h2032_0000, 32, 1'b1, dv, de);
    check_result("post_reset", dv, de, 1'b1, 12'hD20, 8'h00, 8'h00);

    wait_rise(t);
    repeat (5) @(negedge clk);
    check("oe_before_reset", 64'(oe), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_tx_oe", 64'(oe), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/n64_joybus_poller.md
Name: n64_joybus_poller

Overview:
Host-side Joybus engine for the N64 controller port. It periodically sends the poll command (0x01) on the one-wire open-drain line and deserialises the 32-bit status reply. It maps the reply onto the shared 12-bit button vector, with the analog stick folded into the D-pad. The block sits between the N64 pad pin and controller_SM's N64 input. The top level owns the tristate: N64 is driven low when n64_oe=1 and is high-Z otherwise.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency; US_CYC = CLK_FREQ_HZ/1000000 cycles per microsecond.
POLL_PERIOD_US, 16000, interval between poll starts.
TIMEOUT_US, 200, maximum wait for the reply start or for any next falling edge.
STICK_THRESH, 32, magnitude beyond which the stick asserts a D-pad direction (0..127).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
n64_in  input  1  raw pad level, asynchronous.
n64_oe  output  1  1 = pull the line low.
buttons  output  12  [0]up [1]down [2]left [3]right [4]start [5]select [6]A [7]B [8]X [9]Y [10]L [11]R; 1 = pressed.
stick_x  output  8  signed; right is positive.
stick_y  output  8  signed; up is positive.
valid  output  1  one-cycle pulse when buttons and stick update.
present  output  1  1 after a good reply; 0 after a timeout.
err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (reset=0, asynchronous): n64_oe=0, buttons=0, stick_x=0, stick_y=0, valid=0, present=0, err=0. State goes to IDLE and the poll timer clears. The first poll starts POLL_PERIOD_US after reset deasserts.
- n64_in passes through a 2-flop synchroniser. A falling edge is sync=0 while the previous sync=1.
- Bit encoding, one bit every 4 us:
  - '0' = 3 us low, then 1 us released.
  - '1' = 1 us low, then 3 us released.
- State machine:
  - IDLE: count the poll timer, reaching zero at POLL_PERIOD_US, then go to TX.
  - TX: send 0x01 MSB-first, then one stop bit encoded as '1'. That is 9 bits, 36 us total. Falling edges are ignored during TX (own echo). Then go to RX_WAIT.
  - RX_WAIT: wait for a falling edge. If none arrives within TIMEOUT_US, go to ERROR. On the edge, go to RX_BIT.
  - RX_BIT: at 2 us after the edge, sample sync (1 → bit=1) and shift the bit in MSB-first; increment bit_cnt.
    - If bit_cnt < 32, return to RX_WAIT with the timeout timer restarted.
    - After bit 32, go to RX_STOP.
  - RX_STOP: wait for the controller stop bit, i.e. a falling edge followed by the line high. A timeout here goes to ERROR. Otherwise go to UPDATE.
  - UPDATE: one cycle. Register the outputs, set valid=1, present=1, reload the poll timer, go to IDLE.
  - ERROR: one cycle. err=1, present=0, buttons=0, stick_x=0, stick_y=0, reload the poll timer, go to IDLE.
- Reply layout, MSB first:
  - byte0 = A, B, Z, Start, Dup, Ddown, Dleft, Dright.
  - byte1 = rst, rsvd, L, R, Cup, Cdown, Cleft, Cright.
  - byte2 = X stick, byte3 = Y stick.
- Mapping: select=Z, X=Cleft, Y=Cdown; A, B, Start, L, R map directly.
  - up = Dup | (Y > +STICK_THRESH)
  - down = Ddown | (Y < -STICK_THRESH)
  - right = Dright | (X > +STICK_THRESH)
  - left = Dleft | (X < -STICK_THRESH)
  - All comparisons are signed 8-bit and strict. X/Y = -128 counts as beyond any threshold.
- Latency: outputs change in the UPDATE cycle, at most 2 clocks plus the synchroniser delay after the stop bit's rising edge. Outputs hold their values between updates.
- The poll timer does not run during TX or RX, so the actual interval is at least POLL_PERIOD_US.
- Reset mid-TX releases the line immediately, because n64_oe is cleared asynchronously.
- A partial reply never reaches the outputs.

Decomposition:
- Package n64_pkg holds:
  - the state enum (IDLE, TX, RX_WAIT, RX_BIT, RX_STOP, UPDATE, ERROR);
  - POLL_CMD = 8'h01, RESP_BITS = 32, TX_BITS = 9;
  - the 12-bit button index localparams, shared with the controller_SM and serialiser blocks;
  - the bit-timing constants in microseconds (1, 2, 3, 4).
- One sub-module, n64_line_sync: 2-flop synchroniser plus falling-edge pulse. The rest is one FSM with a microsecond prescaler.

Test Plan:
1. Reset release, no activity → n64_oe first rises at 16000 us. It then follows 7 × (36 cycles low / 12 released), followed by 2 × (12 low / 36 released), and then stays released.
2. Model replies 0x90,0x00,0x00,0x00 → one valid pulse, buttons=12'h050, stick 0/0, present=1.
3. Reply with byte2=0x00, byte3=+40 → buttons=12'h001. Same reply with byte3=+32 → buttons=12'h000. byte2=0x80 (-128) → buttons=12'h004.
4. Reply byte1=0x32 (L, R, Cleft) plus Z in byte0=0x20 → buttons=12'hD20.
5. No reply → err pulses at 200 us after the TX stop bit; present=0, buttons=0; the next poll starts 16000 us later. Reply stopped after 20 bits → err pulses, outputs are not updated from the partial data.
6. Reset asserted during RX bit 15 → all outputs 0 immediately. A later full reply to the next poll updates the outputs normally.
